demux_onehot_reg: RTL and testbench
===================================

Name: demux_onehot_reg

Overview:
- Registered 1-to-N demultiplexer: the write-side counterpart of the one-hot channel multiplexers in the ALU datapath.
- Takes one bus word plus a binary channel index.
- Decodes the index to a one-hot select and loads the word into that channel's holding register.
- Each channel register is held until the downstream consumer acknowledges it; per-channel valid flags form a one-hot/multi-hot vector that downstream one-hot muxes can use directly.

Parameters:
- bus_size, 32, data word width in bits.
- NUM_CH, 16, number of output channels (2..16).
- SEL_W, 4, binary select width; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents in_sel/in_data this cycle.
- in_ready  output  1  combinational; block can accept the presented word this cycle.
- in_sel  input  SEL_W  binary destination channel index.
- in_data  input  bus_size  word to route.
- out_data  output  NUM_CH*bus_size  flattened channel registers; channel k occupies bits [k*bus_size +: bus_size].
- out_valid  output  NUM_CH  bit k=1 means channel k holds an unconsumed word.
- out_ack  input  NUM_CH  bit k=1 means the consumer takes channel k this cycle (only meaningful when out_valid[k]=1).
- last_sel  output  NUM_CH  registered one-hot of the most recently accepted in-range write.
- occupancy  output  SEL_W+1  count of set out_valid bits.
- sel_err  output  1  one-cycle pulse: an out-of-range in_sel was accepted and dropped.

Behaviour:
- Reset (asynchronous, while rst=1): out_data=0, out_valid=0, last_sel=0, occupancy=0, sel_err=0.
- Decode: onehot = (in_sel < NUM_CH) ? (1 << in_sel) : 0.
- in_ready:
  - in-range in_sel: in_ready = !out_valid[in_sel] | out_ack[in_sel].
  - out-of-range in_sel: in_ready = 1.
  - in_ready is independent of in_valid.
- Accept condition: in_valid & in_ready, sampled at the clk rising edge.
- Accepted in-range write, channel k:
  - next cycle: out_data[k]=in_data, out_valid[k]=1, last_sel=onehot.
  - Latency is exactly 1 clock.
- Accepted out-of-range write:
  - No channel changes; last_sel holds.
  - sel_err=1 for exactly one cycle. sel_err is 0 in every other cycle.
- Consume: out_ack[k] & out_valid[k] clears out_valid[k] next cycle. out_data[k] holds its stale value; it is not cleared.
- out_ack[k] while out_valid[k]=0 is ignored.
- Simultaneous ack and write to the same channel k: the write wins. out_valid[k] stays 1, out_data[k] takes the new word, occupancy is unchanged.
- Multiple out_ack bits in one cycle are all honoured.
- occupancy:
  - registered; equals the popcount of out_valid in the same cycle.
  - next value = current − (number of honoured acks) + (1 if an in-range write set a previously-clear valid bit).
  - range 0..NUM_CH, never wraps.
- Full (occupancy=NUM_CH): in_ready=1 only for a channel whose ack is asserted that cycle.
- Empty: acks have no effect.
- Reset mid-operation: all state clears immediately; any in-flight accept is lost. The first accept can occur at the first rising edge after rst deasserts.
- Control state machine, per channel, two states:
  - EMPTY -> FULL on write.
  - FULL -> EMPTY on ack without write.
  - FULL -> FULL on write with or without ack.
  - No other transitions.
- No combinational path from out_ack to out_data/out_valid. The only combinational paths are from in_sel/out_ack to in_ready.

Decomposition:
- Shared package alu_mux_pkg:
  - constants BUS_SIZE=32, NUM_CH=16, SEL_W=4.
  - function to_onehot(sel) returning the NUM_CH-bit one-hot, 0 when out of range.
  - function popcount for NUM_CH bits.
- One natural sub-module: onehot_decoder (binary in_sel -> NUM_CH one-hot plus in_range flag, purely combinational). The same decoder can drive the select inputs of the existing one-hot muxes.
- Channel registers and the occupancy counter stay in the top module.

Test Plan:
- Reset then idle -> out_valid=0, occupancy=0, in_ready=1 for all in_sel 0..15, last_sel=0.
- Write in_sel=10, in_data=32'h0470_4400 -> next cycle out_valid=16'h0400, out_data ch10=32'h0470_4400, last_sel=16'h0400, occupancy=1.
- Channel 10 full with no ack, present in_sel=10 in_valid=1 -> in_ready=0, no state change. Then assert out_ack[10] the same cycle -> accepted; ch10 holds the new word, out_valid[10]=1, occupancy=1.
- Fill all 16 channels (data = 32'h1000_0000+k) -> occupancy=16. Ack bits 0,3,15 together -> occupancy=13, out_valid=16'h7FF6. out_data for the acked channels is unchanged.
- NUM_CH=12 build: write in_sel=13 -> in_ready=1, sel_err pulses for 1 cycle, out_valid/last_sel/occupancy unchanged.
- Fill channels 2 and 5, assert rst asynchronously mid-cycle with in_valid=1 -> outputs zero before the next edge. After release, a write to channel 5 yields occupancy=1.

Source files
------------

// File: rtl/alu_mux_pkg.sv
// Shared constants, channel state type and helper functions for the ALU
// one-hot mux/demux datapath.
package alu_mux_pkg;

   localparam int unsigned BUS_SIZE = 32;
   localparam int unsigned NUM_CH   = 16;
   localparam int unsigned SEL_W    = 4;

   typedef enum logic {
      ChEmpty,
      ChFull
   } ch_state_e;

   // Out-of-range selects decode to all zeros.
   function automatic logic [NUM_CH-1:0] to_onehot(input logic [SEL_W-1:0] sel);
      logic [NUM_CH-1:0] oh;
      oh = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         oh[k] = (sel == SEL_W'(k));
      end
      return oh;
   endfunction

   function automatic logic [SEL_W:0] popcount(input logic [NUM_CH-1:0] v);
      logic [SEL_W:0] cnt;
      cnt = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         cnt = cnt + (SEL_W+1)'(v[k]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary channel index to one-hot select; indices >= NUM_CH decode to zero
// and clear in_range_o.
module onehot_decoder #(
   parameter int unsigned NUM_CH = 16,
   parameter int unsigned SEL_W  = 4
) (
   input  logic [SEL_W-1:0]  sel_i,
   output logic [NUM_CH-1:0] onehot_o,
   output logic              in_range_o
);

   always_comb begin
      onehot_o = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         onehot_o[k] = (sel_i == SEL_W'(k));
      end
   end

   assign in_range_o = |onehot_o;

endmodule

// File: rtl/demux_onehot_reg.sv
// Registered 1-to-N demultiplexer: routes one word into a per-channel holding
// register that is held until acknowledged by the downstream consumer.
module demux_onehot_reg
   import alu_mux_pkg::*;
#(
   parameter int unsigned bus_size = BUS_SIZE,
   parameter int unsigned NUM_CH   = alu_mux_pkg::NUM_CH,
   parameter int unsigned SEL_W    = alu_mux_pkg::SEL_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SEL_W-1:0]           in_sel,
   input  logic [bus_size-1:0]        in_data,
   output logic [NUM_CH*bus_size-1:0] out_data,
   output logic [NUM_CH-1:0]          out_valid,
   input  logic [NUM_CH-1:0]          out_ack,
   output logic [NUM_CH-1:0]          last_sel,
   output logic [SEL_W:0]             occupancy,
   output logic                       sel_err
);

   localparam int unsigned MaxCh = alu_mux_pkg::NUM_CH;

   logic [NUM_CH-1:0]               onehot;
   logic                            in_range;
   logic                            accept;
   logic [NUM_CH-1:0]               wr_en;

   ch_state_e                       state_q [NUM_CH];
   ch_state_e                       state_d [NUM_CH];
   logic [NUM_CH-1:0]               valid_d;
   logic [MaxCh-1:0]                valid_ext;
   logic [NUM_CH-1:0][bus_size-1:0] data_q, data_d;
   logic [NUM_CH-1:0]               last_sel_q, last_sel_d;
   logic [SEL_W:0]                  occ_q, occ_d;
   logic                            sel_err_q, sel_err_d;

   onehot_decoder #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_decoder (
      .sel_i      (in_sel),
      .onehot_o   (onehot),
      .in_range_o (in_range)
   );

   // Blocked only when the addressed channel is full and not being drained;
   // out-of-range selects decode to zero and are always ready.
   assign in_ready = ~|(onehot & out_valid & ~out_ack);
   assign accept   = in_valid & in_ready;
   assign wr_en    = accept ? onehot : '0;

   always_comb begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
         out_valid[k] = (state_q[k] == ChFull);
      end
   end

   always_comb begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
         state_d[k] = state_q[k];
         data_d[k]  = data_q[k];
         unique case (state_q[k])
            ChEmpty: if (wr_en[k]) state_d[k] = ChFull;
            ChFull:  if (out_ack[k] && !wr_en[k]) state_d[k] = ChEmpty;
         endcase
         if (wr_en[k]) data_d[k] = in_data;
         valid_d[k] = (state_d[k] == ChFull);
      end

      valid_ext               = '0;
      valid_ext[NUM_CH-1:0]   = valid_d;
      occ_d                   = (SEL_W+1)'(popcount(valid_ext));

      last_sel_d = (accept && in_range) ? onehot : last_sel_q;
      sel_err_d  = accept && !in_range;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(NUM_CH); k++) begin
            state_q[k] <= ChEmpty;
         end
         data_q     <= '0;
         last_sel_q <= '0;
         occ_q      <= '0;
         sel_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         last_sel_q <= last_sel_d;
         occ_q      <= occ_d;
         sel_err_q  <= sel_err_d;
      end
   end

   assign out_data  = data_q;
   assign last_sel  = last_sel_q;
   assign occupancy = occ_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_onehot_reg.sv
// Bench for demux_onehot_reg: reference model plus per-cycle compare, with
// directed literal checks on a 16-channel and a 12-channel build.
module tb_demux_onehot_reg;

   localparam int NCH = 16;
   localparam int BW  = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        in_sel = '0;
   logic [BW-1:0]     in_data = '0;
   logic [NCH*BW-1:0] out_data;
   logic [NCH-1:0]    out_valid;
   logic [NCH-1:0]    out_ack = '0;
   logic [NCH-1:0]    last_sel;
   logic [4:0]        occupancy;
   logic              sel_err;

   logic              v12 = 1'b0;
   logic              rdy12;
   logic [3:0]        sel12 = '0;
   logic [BW-1:0]     data12 = '0;
   logic [12*BW-1:0]  odata12;
   logic [11:0]       ovalid12;
   logic [11:0]       ack12 = '0;
   logic [11:0]       last12;
   logic [4:0]        occ12;
   logic              err12;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   demux_onehot_reg dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .last_sel  (last_sel),
      .occupancy (occupancy),
      .sel_err   (sel_err)
   );

   demux_onehot_reg #(
      .bus_size (32),
      .NUM_CH   (12),
      .SEL_W    (4)
   ) dut12 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v12),
      .in_ready  (rdy12),
      .in_sel    (sel12),
      .in_data   (data12),
      .out_data  (odata12),
      .out_valid (ovalid12),
      .out_ack   (ack12),
      .last_sel  (last12),
      .occupancy (occ12),
      .sel_err   (err12)
   );

   // Reference model: per-channel word and full flag held in plain arrays.
   bit [NCH-1:0]  m_valid;
   logic [BW-1:0] m_data [NCH];
   bit [NCH-1:0]  m_last;
   int            m_occ;
   bit            m_err;

   function automatic bit model_ready();
      if (int'(in_sel) >= NCH) return 1'b1;
      return !m_valid[in_sel] || out_ack[in_sel];
   endfunction

   always @(posedge clk or posedge rst) begin
      bit acc;
      if (rst) begin
         m_valid = '0;
         for (int k = 0; k < NCH; k++) m_data[k] = '0;
         m_last = '0;
         m_occ  = 0;
         m_err  = 1'b0;
      end else begin
         acc = in_valid && model_ready();
         for (int k = 0; k < NCH; k++) if (out_ack[k]) m_valid[k] = 1'b0;
         m_err = 1'b0;
         if (acc) begin
            if (int'(in_sel) < NCH) begin
               m_valid[in_sel] = 1'b1;
               m_data[in_sel]  = in_data;
               m_last          = '0;
               m_last[in_sel]  = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end
         m_occ = 0;
         for (int k = 0; k < NCH; k++) m_occ += int'(m_valid[k]);
      end
   end

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [NCH*BW-1:0] flat;
      if (!rst && cmp_en) begin
         for (int k = 0; k < NCH; k++) flat[k*BW +: BW] = m_data[k];
         chk("cmp_out_valid", 512'(out_valid), 512'(m_valid));
         chk("cmp_out_data", 512'(out_data), 512'(flat));
         chk("cmp_last_sel", 512'(last_sel), 512'(m_last));
         chk("cmp_occupancy", 512'(occupancy), 512'(m_occ));
         chk("cmp_sel_err", 512'(sel_err), 512'(m_err));
         chk("cmp_in_ready", 512'(in_ready), 512'(model_ready()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BW-1:0] ch(input int k);
      return out_data[k*BW +: BW];
   endfunction

   initial begin
      #12 rst = 1'b0;
      cmp_en = 1'b1;

      // Idle after reset
      chk("rst_valid", 512'(out_valid), 512'(16'h0000));
      chk("rst_occ", 512'(occupancy), 512'(0));
      chk("rst_last", 512'(last_sel), 512'(16'h0000));
      chk("rst_err", 512'(sel_err), 512'(0));
      for (int s = 0; s < 16; s++) begin
         in_sel = 4'(s);
         #1;
         chk("idle_ready", 512'(in_ready), 512'(1));
      end

      // Single write to channel 10
      in_valid = 1'b1; in_sel = 4'd10; in_data = 32'h0470_4400;
      step();
      in_valid = 1'b0;
      chk("w10_valid", 512'(out_valid), 512'(16'h0400));
      chk("w10_data", 512'(ch(10)), 512'(32'h0470_4400));
      chk("w10_last", 512'(last_sel), 512'(16'h0400));
      chk("w10_occ", 512'(occupancy), 512'(1));

      // Full channel blocks, then write-with-ack on the same channel
      in_valid = 1'b1; in_sel = 4'd10; in_data = 32'hCAFE_0010;
      #1 chk("blk_ready", 512'(in_ready), 512'(0));
      step();
      chk("blk_data", 512'(ch(10)), 512'(32'h0470_4400));
      out_ack = 16'h0400;
      #1 chk("ackw_ready", 512'(in_ready), 512'(1));
      step();
      in_valid = 1'b0; out_ack = '0;
      chk("ackw_data", 512'(ch(10)), 512'(32'hCAFE_0010));
      chk("ackw_valid", 512'(out_valid), 512'(16'h0400));
      chk("ackw_occ", 512'(occupancy), 512'(1));

      // Drain, fill all 16, then multi-ack
      out_ack = 16'hFFFF;
      step();
      out_ack = '0;
      chk("drain_valid", 512'(out_valid), 512'(16'h0000));
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1; in_sel = 4'(k); in_data = 32'h1000_0000 + 32'(k);
         step();
      end
      in_valid = 1'b0;
      chk("fill_occ", 512'(occupancy), 512'(16));
      chk("fill_valid", 512'(out_valid), 512'(16'hFFFF));
      in_valid = 1'b1; in_sel = 4'd7; in_data = 32'hDEAD_0007;
      #1 chk("full_ready", 512'(in_ready), 512'(0));
      out_ack = 16'h0080;
      #1 chk("full_ack_ready", 512'(in_ready), 512'(1));
      in_valid = 1'b0; out_ack = 16'h8009;
      step();
      out_ack = '0;
      chk("mack_valid", 512'(out_valid), 512'(16'h7FF6));
      chk("mack_occ", 512'(occupancy), 512'(13));
      chk("mack_d0", 512'(ch(0)), 512'(32'h1000_0000));
      chk("mack_d3", 512'(ch(3)), 512'(32'h1000_0003));
      chk("mack_d15", 512'(ch(15)), 512'(32'h1000_000F));

      // 12-channel build: out-of-range select is accepted and dropped
      v12 = 1'b1; sel12 = 4'd3; data12 = 32'h0000_0333;
      step();
      chk("c12_valid", 512'(ovalid12), 512'(12'h008));
      chk("c12_occ", 512'(occ12), 512'(1));
      sel12 = 4'd13; data12 = 32'hBAD0_0013;
      #1 chk("c12_oor_ready", 512'(rdy12), 512'(1));
      step();
      v12 = 1'b0;
      chk("c12_err", 512'(err12), 512'(1));
      chk("c12_oor_valid", 512'(ovalid12), 512'(12'h008));
      chk("c12_oor_last", 512'(last12), 512'(12'h008));
      chk("c12_oor_occ", 512'(occ12), 512'(1));
      step();
      chk("c12_err_clr", 512'(err12), 512'(0));

      // Asynchronous reset mid-cycle with a write pending
      out_ack = 16'hFFFF;
      step();
      out_ack = '0;
      in_valid = 1'b1; in_sel = 4'd2; in_data = 32'h0000_0222;
      step();
      in_sel = 4'd5; in_data = 32'h0000_0555;
      step();
      in_sel = 4'd7; in_data = 32'h0000_0777;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", 512'(out_valid), 512'(16'h0000));
      chk("arst_occ", 512'(occupancy), 512'(0));
      chk("arst_last", 512'(last_sel), 512'(16'h0000));
      chk("arst_data", 512'(out_data), 512'(0));
      in_valid = 1'b0;
      #1 rst = 1'b0;
      step();
      in_valid = 1'b1; in_sel = 4'd5; in_data = 32'h0000_5555;
      step();
      in_valid = 1'b0;
      chk("post_occ", 512'(occupancy), 512'(1));
      chk("post_valid", 512'(out_valid), 512'(16'h0020));
      chk("post_last", 512'(last_sel), 512'(16'h0020));
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
